// File: rtl/fir_out_serializer_if.sv
// Handshake bundle for the FIR output serializer: 3-sample parallel words in,
// one serial sample per clock out, plus occupancy and overflow status.
interface fir_out_serializer_if #(
  parameter int NB = 14,
  parameter int LW = 3
);
  logic          vin;
  logic [NB-1:0] din0;
  logic [NB-1:0] din1;
  logic [NB-1:0] din2;
  logic          rdy_in;
  logic [NB-1:0] dout;
  logic          vout;
  logic          rdy_out;
  logic [LW-1:0] level;
  logic          ovf;

  modport master (
    output vin, din0, din1, din2, rdy_out,
    input  rdy_in, dout, vout, level, ovf
  );

  modport slave (
    input  vin, din0, din1, din2, rdy_out,
    output rdy_in, dout, vout, level, ovf
  );
endinterface

// File: rtl/fir_out_serializer.sv
// Buffers 3-sample words from the unfolded FIR in a small FIFO and replays
// them one sample per accepted cycle in time order (din0, din1, din2).
//
// state | meaning
// PH0   | head word sample 0 (time 3k) on dout
// PH1   | head word sample 1 (time 3k+1) on dout
// PH2   | head word sample 2 (time 3k+2) on dout; acceptance retires the word
module fir_out_serializer #(
  parameter int NB    = 14,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input logic                 clk,
  input logic                 rst_n,
  fir_out_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {PH0, PH1, PH2} ph_t;

  ph_t             ph;
  ph_t             ph_nxt;
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [LW-1:0]   cnt;
  logic            ovf;
  logic [3*NB-1:0] mem [DEPTH];
  logic [3*NB-1:0] head;
  logic [NB-1:0]   dout;
  logic            rdy_in;
  logic            vout;
  logic            push;
  logic            drop;
  logic            xfer;
  logic            retire;

  // Ready comes from cnt alone so rdy_out never reaches rdy_in combinationally.
  assign rdy_in = (cnt < LW'(DEPTH));
  assign vout   = (cnt != '0);
  assign push   = bus.vin & rdy_in;
  assign drop   = bus.vin & ~rdy_in;
  assign xfer   = vout & bus.rdy_out;
  assign retire = xfer & (ph == PH2);

  always_comb begin
    ph_nxt = ph;
    if (xfer) begin
      case (ph)
        PH0:     ph_nxt = PH1;
        PH1:     ph_nxt = PH2;
        default: ph_nxt = PH0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= PH0;
    else        ph <= ph_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push)   wp <= wp + 1'b1;
      if (retire) rp <= rp + 1'b1;
      case ({push, retire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  // Storage is not reset; cnt gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {bus.din2, bus.din1, bus.din0};
  end

  assign head = mem[rp];

  always_comb begin
    dout = '0;
    if (vout) begin
      case (ph)
        PH0:     dout = head[NB-1:0];
        PH1:     dout = head[2*NB-1:NB];
        default: dout = head[3*NB-1:2*NB];
      endcase
    end
  end

  assign bus.rdy_in = rdy_in;
  assign bus.vout   = vout;
  assign bus.dout   = dout;
  assign bus.level  = cnt;
  assign bus.ovf    = ovf;
endmodule

// File: tb/tb_fir_out_serializer.sv
// Directed plus randomized bench for fir_out_serializer against a queue-of-words
// reference model of the serializer's behaviour.
module tb_fir_out_serializer;
  localparam int NB    = 14;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;

  fir_out_serializer_if #(.NB(NB), .LW(LW)) bus ();

  fir_out_serializer #(.NB(NB), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: whole words queued oldest first, index of the sample on show.
  logic [3*NB-1:0] mq[$];
  int              mph  = 0;
  bit              movf = 0;

  task automatic model_clear();
    mq.delete();
    mph  = 0;
    movf = 0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3*NB-1:0] w;
    logic [NB-1:0]   exp_dout;
    exp_dout = '0;
    if (mq.size() != 0) begin
      w        = mq[0];
      exp_dout = w[mph*NB +: NB];
    end
    check("vout",   32'(bus.vout),   32'(mq.size() != 0));
    check("dout",   32'(bus.dout),   32'(exp_dout));
    check("rdy_in", 32'(bus.rdy_in), 32'(mq.size() < DEPTH));
    check("level",  32'(bus.level),  32'(mq.size()));
    check("ovf",    32'(bus.ovf),    32'(movf));
  endtask

  // Check the current cycle, take one rising edge, advance the model.
  task automatic step();
    bit can_push;
    check_all();
    @(posedge clk);
    can_push = (mq.size() < DEPTH);
    if (mq.size() != 0 && bus.rdy_out) begin
      if (mph == 2) begin
        mph = 0;
        void'(mq.pop_front());
      end else begin
        mph++;
      end
    end
    if (bus.vin && can_push)  mq.push_back({bus.din2, bus.din1, bus.din0});
    if (bus.vin && !can_push) movf = 1;
    @(negedge clk);
  endtask

  task automatic set_word(logic [NB-1:0] a, logic [NB-1:0] b, logic [NB-1:0] c);
    bus.din0 = a;
    bus.din1 = b;
    bus.din2 = c;
  endtask

  task automatic push_word(logic [NB-1:0] a, logic [NB-1:0] b, logic [NB-1:0] c);
    set_word(a, b, c);
    bus.vin = 1'b1;
    step();
    bus.vin = 1'b0;
  endtask

  initial begin
    logic [NB-1:0] base;

    // 1: reset with vin high, then a single word through
    rst_n       = 1'b0;
    bus.vin     = 1'b1;
    bus.rdy_out = 1'b1;
    set_word(NB'($urandom), NB'($urandom), NB'($urandom));
    model_clear();
    #12;
    check_all();
    check("rst_rdy_in", 32'(bus.rdy_in), 32'd1);
    @(negedge clk);
    rst_n   = 1'b1;
    bus.vin = 1'b0;
    step();
    push_word(14'd100, 14'd200, 14'd300);
    check("t1_s0", 32'(bus.dout), 32'd100);
    step();
    check("t1_s1", 32'(bus.dout), 32'd200);
    step();
    check("t1_s2", 32'(bus.dout), 32'd300);
    step();
    check("t1_empty_vout", 32'(bus.vout), 32'd0);
    check("t1_empty_lvl",  32'(bus.level), 32'd0);
    step();

    // 2: backpressure while the middle sample is showing
    push_word(NB'(-5), NB'(7), NB'(-8192));
    step();
    bus.rdy_out = 1'b0;
    step();
    step();
    check("t2_hold", 32'(bus.dout), 32'd7);
    bus.rdy_out = 1'b1;
    step();
    check("t2_neg", 32'(bus.dout), 32'(14'h2000));
    step();
    step();

    // 3: fill, overflow, drain
    bus.rdy_out = 1'b0;
    for (int i = 0; i < 4; i++)
      push_word(NB'(3*i+1), NB'(3*i+2), NB'(3*i+3));
    check("t3_full_lvl", 32'(bus.level), 32'd4);
    check("t3_full_rdy", 32'(bus.rdy_in), 32'd0);
    push_word(14'd13, 14'd14, 14'd15);
    check("t3_ovf", 32'(bus.ovf), 32'd1);
    bus.rdy_out = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      check("t3_order", 32'(bus.dout), 32'(i));
      step();
    end
    check("t3_drop", 32'(bus.vout), 32'd0);
    step();

    // 4: push and retire in the same cycle at level 3, then retire at level 4
    bus.rdy_out = 1'b0;
    for (int i = 0; i < 3; i++)
      push_word(NB'(40+3*i), NB'(41+3*i), NB'(42+3*i));
    bus.rdy_out = 1'b1;
    step();
    step();
    check("t4_pre_lvl", 32'(bus.level), 32'd3);
    push_word(14'd60, 14'd61, 14'd62);
    check("t4_post_lvl", 32'(bus.level), 32'd3);
    bus.rdy_out = 1'b0;
    push_word(14'd70, 14'd71, 14'd72);
    bus.rdy_out = 1'b1;
    step();
    step();
    check("t4_full_lvl", 32'(bus.level), 32'd4);
    push_word(14'd80, 14'd81, 14'd82);
    for (int i = 0; i < 14; i++) step();

    // 5: sustained stream, one word every third cycle
    base = NB'($urandom);
    for (int i = 0; i < 100; i++) begin
      set_word(base + NB'(3*i), base + NB'(3*i+1), base + NB'(3*i+2));
      bus.vin = 1'b1;
      for (int j = 0; j < 3; j++) begin
        check("t5_lvl_le1", 32'(bus.level <= 1), 32'd1);
        step();
        bus.vin = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) step();

    // 6: asynchronous reset on the middle sample with two words stored
    bus.rdy_out = 1'b0;
    push_word(14'd21, 14'd22, 14'd23);
    push_word(14'd24, 14'd25, 14'd26);
    bus.rdy_out = 1'b1;
    step();
    check("t6_mid", 32'(bus.dout), 32'd22);
    check("t6_lvl", 32'(bus.level), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    push_word(14'd9, 14'd8, 14'd7);
    check("t6_s0", 32'(bus.dout), 32'd9);
    for (int i = 0; i < 4; i++) step();

    // Random traffic and backpressure
    for (int i = 0; i < 400; i++) begin
      set_word(NB'($urandom), NB'($urandom), NB'($urandom));
      bus.vin     = ($urandom_range(0, 9) < 4);
      bus.rdy_out = ($urandom_range(0, 9) < 7);
      step();
    end
    bus.vin     = 1'b0;
    bus.rdy_out = 1'b1;
    for (int i = 0; i < 15; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_out_serializer.md
# fir_out_serializer

- Converts the 3-parallel output of the unfolded FIR back into a serial stream of one sample per clock.
- Sits between the filter's DOUT0/DOUT1/DOUT2/VOUT outputs and any single-sample consumer, and mirrors the front-end split that feeds DIN0..DIN2.
- Buffers whole 3-sample words in a small FIFO and emits them in time order (DIN0, DIN1, DIN2).
- Provides ready/valid backpressure on both sides, plus a sticky overflow flag for words presented while full.

## Interface

Parameters:
- NB, 14, sample width in bits (two's complement, passed through unmodified)
- DEPTH, 4, FIFO depth in 3-sample words; power of two, ≥2
- LW, clog2(DEPTH)+1, width of LEVEL

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RST_n  in  1  reset, asynchronous, active-low
- VIN  in  1  parallel word valid
- DIN0  in  NB  oldest sample of word (time 3k)
- DIN1  in  NB  sample at time 3k+1
- DIN2  in  NB  sample at time 3k+2
- RDY_IN  out  1  serializer can accept a word this cycle
- DOUT  out  NB  serial sample
- VOUT  out  1  DOUT valid
- RDY_OUT  in  1  downstream accepts DOUT this cycle
- LEVEL  out  LW  number of words stored, including any partially emitted word
- OVF  out  1  sticky: a word was presented while RDY_IN=0

## Operation

Storage and pointers:
- FIFO of DEPTH entries, each 3×NB bits.
- Write pointer wp and read pointer rp, each log2(DEPTH) bits, wrap modulo DEPTH.
- Word counter cnt, 0..DEPTH.
- Phase counter ph, 0..2: selects which sample of the head word is on DOUT.

Push:
- push = VIN & RDY_IN, where RDY_IN = (cnt < DEPTH). RDY_IN is derived from registers only and has no combinational path from RDY_OUT.
- On push: mem[wp] ← {DIN2, DIN1, DIN0}; wp ← wp+1.

Output:
- VOUT = (cnt ≠ 0).
- DOUT = mem[rp] sample ph when VOUT=1, else all zeros.

Pop handshake (xfer = VOUT & RDY_OUT):
- xfer with ph<2: ph ← ph+1.
- xfer with ph=2: ph ← 0; rp ← rp+1; word retired.

Counter update:
- cnt ← cnt + push − retire.
- Simultaneous push and retire leaves cnt unchanged. This is legal, including at cnt=DEPTH−1.
- At cnt=DEPTH, a retire in the same cycle does not enable the push; RDY_IN is already 0.

Drops and overflow:
- VIN=1 while RDY_IN=0: word is discarded and OVF ← 1.
- OVF clears only on reset.

Other rules:
- VOUT=1 with RDY_OUT=0: DOUT, ph and rp hold stable until accepted.
- No arithmetic is performed; samples are bit-exact copies.
- LEVEL = cnt.

## Timing

Reset (RST_n=0, asynchronous):
- wp, rp, ph, cnt ← 0; OVF ← 0.
- Outputs: VOUT=0, DOUT=0, RDY_IN=1, LEVEL=0.
- Memory contents need not be reset.

Latency and throughput:
- A word pushed at edge k is on DOUT (sample 0, VOUT=1) in the cycle after edge k when the FIFO was empty. Pass-through latency is 1 clock.
- With RDY_OUT held high, the three samples of a word appear on three consecutive cycles.
- Next words follow back-to-back with no bubble.
- Maximum sustained input rate: one word per 3 cycles. Faster input fills the FIFO, then RDY_IN drops.

Reset mid-word:
- Remaining samples are lost; ph returns to 0; the stream resumes cleanly with the next pushed word.

## Test plan

1. Reset: hold RST_n=0 with VIN=1 → VOUT=0, DOUT=0, RDY_IN=1, LEVEL=0, OVF=0. Release, push one word {DIN0=100, DIN1=200, DIN2=300} with RDY_OUT=1 → DOUT=100, 200, 300 on the next three cycles, then VOUT=0 and LEVEL=0.
2. Backpressure: push {−5, 7, −8192}; drop RDY_OUT for 2 cycles while DOUT=7 → DOUT holds 7 with VOUT=1. Resume → −8192 follows; values are bit-exact, including sign.
3. Full and overflow:
   - With RDY_OUT=0, push 4 words (1,2,3 / 4,5,6 / 7,8,9 / 10,11,12) → LEVEL=4 and RDY_IN=0.
   - A 5th VIN (13,14,15) → OVF=1 and the word is dropped.
   - Set RDY_OUT=1 → DOUT emits 1..12 in order, and 13..15 never appear.
4. Push/retire collision: with LEVEL=3 and ph=2, assert VIN and RDY_OUT in the same cycle → LEVEL stays 3 and wp, rp and ph update correctly. Also check RDY_IN=0 at LEVEL=4 even when a retire occurs that cycle.
5. Sustained stream: VIN every 3rd cycle with an incrementing ramp and RDY_OUT=1 for 100 words → continuous VOUT, output equals the ramp, LEVEL ≤1, OVF=0.
6. Mid-operation reset: assert RST_n low while DOUT is on the middle sample with LEVEL=2 → outputs go to reset values asynchronously. Push {9, 8, 7} afterwards → output is 9, 8, 7 with no residue.
